// File: rtl/line_mem_responder.sv
// Line-organised 64-bit main memory behind the cache re/we/addr/rdy port.
// One request at a time, completed after a fixed LATENCY with a rdy pulse.
module line_mem_responder #(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic [63:0]       rdata,
  output logic              rdy,
  output logic              busy
);

  localparam int LW    = ADDR_W - 2;
  localparam int DEPTH = 1 << LW;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state;
  state_t          nstate;
  logic [3:0]      cnt;
  logic [LW-1:0]   line_q;
  logic [63:0]     wdata_q;
  logic            wr_q;
  logic            accept;
  logic            fire;
  logic            unused_bits;

  logic [63:0] mem [DEPTH];

  // Word select within a line has no meaning here.
  assign unused_bits = ^addr[1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    accept = 1'b0;
    fire   = 1'b0;
    unique case (state)
      IDLE: begin
        if (re | we) begin
          accept = 1'b1;
          nstate = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          fire   = 1'b1;
          nstate = DONE;
        end
      end
      DONE: begin
        nstate = IDLE;
      end
      default: begin
        nstate = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= 4'd0;
      rdy     <= 1'b0;
      busy    <= 1'b0;
      rdata   <= 64'd0;
      line_q  <= '0;
      wdata_q <= 64'd0;
      wr_q    <= 1'b0;
    end else begin
      rdy  <= fire;
      busy <= (nstate != IDLE);
      if (accept) begin
        line_q  <= addr[ADDR_W-1:2];
        wdata_q <= wdata;
        wr_q    <= we;
        cnt     <= CNT_INIT;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (fire && !wr_q) begin
        rdata <= mem[line_q];
      end
    end
  end

  // Storage is never cleared; a reset edge suppresses a pending commit.
  always_ff @(posedge clk) begin
    if (rst && fire && wr_q) begin
      mem[line_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder.
// Covers latency, ignore-while-busy, re+we, reset abort, held re, sweep.
module tb_line_mem_responder;

  logic        clk;
  logic        rst;
  logic        re, we;
  logic [15:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        rdy, busy;

  logic        sre, swe;
  logic [15:0] saddr;
  logic [63:0] swdata;
  logic [63:0] rdata1, rdata15;
  logic        rdy1, busy1, rdy15, busy15;

  int nchecks = 0;
  int nerrors = 0;

  localparam logic [63:0] LINE40 = 64'h0022_0011_AAAA_5555;

  line_mem_responder #(.ADDR_W(16), .LATENCY(4)) u_dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rdy(rdy), .busy(busy)
  );

  line_mem_responder #(.ADDR_W(16), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .re(sre), .we(swe), .addr(saddr),
    .wdata(swdata), .rdata(rdata1), .rdy(rdy1), .busy(busy1)
  );

  line_mem_responder #(.ADDR_W(16), .LATENCY(15)) u_l15 (
    .clk(clk), .rst(rst), .re(sre), .we(swe), .addr(saddr),
    .wdata(swdata), .rdata(rdata15), .rdy(rdy15), .busy(busy15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // lat = posedges from accept edge to the edge that raised rdy
  task automatic access(input logic r, input logic w,
                        input logic [15:0] a, input logic [63:0] d,
                        input bit inject, output int lat,
                        output logic [63:0] data);
    @(negedge clk);
    re = r; we = w; addr = a; wdata = d;
    @(negedge clk);
    re = 1'b0; we = 1'b0;
    lat = 0;
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    while (!rdy && lat < 40) begin
      @(negedge clk);
      lat++;
      if (inject && lat == 1) begin
        we = 1'b1; addr = 16'h0040; wdata = 64'd0;
      end else if (inject && lat == 2) begin
        we = 1'b0;
      end
    end
    data = rdata;
    @(negedge clk);
    check("rdy_one_cycle", {63'd0, rdy}, 64'd0);
    check("busy_cleared", {63'd0, busy}, 64'd0);
  endtask

  task automatic sweep(input logic r, input logic w,
                       input logic [15:0] a, input logic [63:0] d,
                       output int l1, output int l15,
                       output logic [63:0] d1, output logic [63:0] d15);
    @(negedge clk);
    sre = r; swe = w; saddr = a; swdata = d;
    @(negedge clk);
    sre = 1'b0; swe = 1'b0;
    l1 = -1; l15 = -1; d1 = '0; d15 = '0;
    for (int k = 0; k < 30; k++) begin
      if (rdy1 && l1 < 0) begin l1 = k; d1 = rdata1; end
      if (rdy15 && l15 < 0) begin l15 = k; d15 = rdata15; end
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, l1, l15, npulse, bad;
    int pulses[4];
    logic [63:0] data, d1, d15;

    rst = 1'b0; re = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    sre = 1'b0; swe = 1'b0; saddr = '0; swdata = '0;
    repeat (3) @(negedge clk);
    check("reset_rdy", {63'd0, rdy}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_rdata", rdata, 64'd0);
    check("reset_busy15", {63'd0, busy15}, 64'd0);
    rst = 1'b1;

    // write then read with ignored word bits
    access(1'b0, 1'b1, 16'h0040, LINE40, 1'b0, lat, data);
    check("wr_latency", 64'(lat), 64'd4);
    check("wr_rdata_kept", data, 64'd0);
    access(1'b1, 1'b0, 16'h0042, 64'd0, 1'b0, lat, data);
    check("rd_latency", 64'(lat), 64'd4);
    check("rd_data", data, LINE40);

    // write pulse during BUSY must be ignored
    access(1'b1, 1'b0, 16'h0040, 64'd0, 1'b1, lat, data);
    check("ign_latency", 64'(lat), 64'd4);
    check("ign_data", data, LINE40);
    access(1'b1, 1'b0, 16'h0041, 64'd0, 1'b0, lat, data);
    check("ign_later_read", data, LINE40);

    // re and we together act as a write
    access(1'b1, 1'b1, 16'h0100, 64'h1234, 1'b0, lat, data);
    check("both_rdata_kept", data, LINE40);
    access(1'b1, 1'b0, 16'h0100, 64'd0, 1'b0, lat, data);
    check("both_read_back", data, 64'h1234);

    // reset two cycles into a write aborts it
    access(1'b0, 1'b1, 16'h0200, 64'hBEEF, 1'b0, lat, data);
    @(negedge clk);
    we = 1'b1; addr = 16'h0200; wdata = 64'hDEAD;
    @(negedge clk);
    we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_rdata", rdata, 64'd0);
    rst = 1'b1;
    npulse = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rdy) npulse++;
    end
    check("rst_no_rdy", 64'(npulse), 64'd0);
    access(1'b1, 1'b0, 16'h0200, 64'd0, 1'b0, lat, data);
    check("rst_no_commit", data, 64'hBEEF);

    // re held high: pulse every LATENCY+2 cycles, rdata holds
    @(negedge clk);
    re = 1'b1; addr = 16'h0040;
    npulse = 0; bad = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rdy && npulse < 4) begin
        pulses[npulse] = i;
        npulse++;
      end
      if (i >= 5 && rdata !== LINE40) bad++;
    end
    re = 1'b0;
    check("held_pulses", 64'(npulse), 64'd3);
    check("held_first", 64'(pulses[0]), 64'd5);
    check("held_gap1", 64'(pulses[1] - pulses[0]), 64'd6);
    check("held_gap2", 64'(pulses[2] - pulses[1]), 64'd6);
    check("held_rdata", 64'(bad), 64'd0);
    lat = 0;
    while (busy && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("held_drain", {63'd0, busy}, 64'd0);

    // latency sweep: LATENCY=1 and LATENCY=15
    sweep(1'b0, 1'b1, 16'h0040, LINE40, l1, l15, d1, d15);
    check("sweep_wr_l1", 64'(l1), 64'd1);
    check("sweep_wr_l15", 64'(l15), 64'd15);
    sweep(1'b1, 1'b0, 16'h0042, 64'd0, l1, l15, d1, d15);
    check("sweep_rd_l1", 64'(l1), 64'd1);
    check("sweep_rd_l15", 64'(l15), 64'd15);
    check("sweep_data_l1", d1, LINE40);
    check("sweep_data_l15", d15, LINE40);

    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/line_mem_responder.md
# line_mem_responder

Multi-cycle main-memory responder answering the line-fill and write-back requests issued by the CPU's cache controller. It holds a line-organised 64-bit storage array and accepts one request at a time. After a fixed, parameterised latency it returns a one-cycle ready pulse, with read data or with the write committed. It sits below the I-cache and D-cache arbiter of the 5-stage pipelined processor and is the far end of the cache's re/we/addr/rdy memory interface.

## Interface
- ADDR_W, 16: word-address width; line address is addr[ADDR_W-1:2]; array depth 2^(ADDR_W-2) lines.
- LATENCY, 4: cycles from request acceptance to rdy; legal range 1..15.
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset, synchronous, active-low.
- re  input  1  read (line fill) request.
- we  input  1  write (write-back) request.
- addr  input  ADDR_W  word address; bits [1:0] ignored.
- wdata  input  64  write line: word 0 in [15:0], word 3 in [63:48].
- rdata  output  64  read line; valid while rdy=1, held afterwards until the next read completes.
- rdy  output  1  one-cycle completion pulse.
- busy  output  1  high while a request is outstanding (BUSY or DONE state).

## Operation
- States:
  - IDLE: no request outstanding.
  - BUSY: countdown running.
  - DONE: completion cycle.
- Reset (rst=0 at posedge): state goes to IDLE. rdy=0, busy=0, rdata=0, counter=0. Storage contents are not altered by reset.
- IDLE, with re|we high at posedge:
  - Latch the line address addr[ADDR_W-1:2], wdata, and op (write if we=1, else read).
  - Load counter with LATENCY-1 and go to BUSY.
  - re and we both high is treated as a write.
- BUSY: decrement the counter each posedge. When counter==0 at a posedge, go to DONE.
- Entering DONE (same edge):
  - Read: rdata is loaded from mem[latched line].
  - Write: mem[latched line] is loaded with the latched wdata; rdata is unchanged.
  - rdy is high for the whole DONE cycle.
- DONE: the next posedge returns to IDLE unconditionally.
- re/we are ignored in BUSY and DONE. They do not restart, queue, or modify the latched request. The requester must deassert re/we in the cycle it sees rdy, or a new request is accepted in the following IDLE cycle.
- Input changes after acceptance have no effect on the outstanding request, because addr and wdata are latched.
- Reset mid-operation aborts the request: no write is committed, and rdy does not pulse.
- Address wrap: none. The line index is exactly ADDR_W-2 bits, so all addresses are in range.

## Timing
- Accept edge = edge A, where IDLE samples re|we=1.
- State is BUSY after edge A, and DONE after edge A+LATENCY.
- rdy=1 during the cycle between edges A+LATENCY and A+LATENCY+1; rdata is valid in that same cycle.
- A write becomes visible to a read accepted at edge A+LATENCY+1 or later.
- busy=1 from edge A until edge A+LATENCY+1.
- Minimum spacing between accept edges is LATENCY+2 cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Write then read:
  - Stimulus: with LATENCY=4, write wdata=64'h0022_0011_AAAA_5555 at addr 16'h0040. Then read addr 16'h0042.
  - Required response: for each access, rdy pulses exactly 4 cycles after acceptance. The read returns 64'h0022_0011_AAAA_5555, showing that addr[1:0] is ignored.
- Ignore while busy:
  - Stimulus: read 16'h0040, then assert we with addr 16'h0040 and wdata=0 during BUSY.
  - Required response: the pulse is ignored; the read returns the prior line, and a later read still shows the old data.
- Simultaneous re and we:
  - Stimulus: re=we=1, addr 16'h0100, wdata=64'h1234.
  - Required response: treated as a write; rdata is unchanged; a subsequent read of 16'h0100 returns 64'h1234.
- Reset mid-write:
  - Stimulus: drive rst=0 two cycles after accepting a write of 64'hDEAD to 16'h0200.
  - Required response: rdy never pulses; busy=0 and rdata=0 after the reset edge; a later read of 16'h0200 returns the pre-write contents.
- Held request:
  - Stimulus: keep re=1 continuously.
  - Required response: rdy pulses every LATENCY+2 cycles (every 6 cycles), and rdata holds between pulses.
- Latency sweep:
  - Stimulus: repeat the first scenario with LATENCY=1 and LATENCY=15.
  - Required response: rdy arrives 1 cycle and 15 cycles after acceptance, respectively.
